// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence detector.
package seq_det_pkg;

    localparam logic [7:0] DEF_PAT_C = 8'b0000_1001;
    localparam int         DEF_LEN_C = 4;

    function automatic int fill_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int clamp_len(input int len, input int max_len);
        return (len < 1) ? 1 : (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] q_q, q_d;

    assign sat = &q_q;
    assign q   = q_q;

    always_comb q_d = clr ? '0 : (inc && !sat) ? q_q + W'(1) : q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with overlap
// and Mealy/Moore selection plus a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(DEF_PAT_C),
    parameter int                 DEF_LEN = DEF_LEN_C
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [MAX_LEN-1:0]            pat_in,
    input  logic [fill_w(MAX_LEN)-1:0]    len_in,
    input  logic                          overlap_en,
    input  logic                          mealy_mode,
    input  logic                          clr,
    input  logic                          valid,
    input  logic                          j,
    output logic                          w,
    output logic [CNT_W-1:0]              match_cnt,
    output logic                          cnt_sat
);

    localparam int LW = fill_w(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               mealy_q, mealy_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               w_q, w_d;
    logic [MAX_LEN-1:0] win, mask;
    logic               hit, m;

    // Window of the newest MAX_LEN bits with the current bit as LSB; only the low len bits count.
    assign win  = {hist_q, j};
    assign mask = {MAX_LEN{1'b1}} >> (MAX_LEN - int'(len_q));
    assign hit  = ((win ^ pat_q) & mask) == '0;
    assign m    = rst_n && !load && valid && (int'(fill_q) >= int'(len_q) - 1) && hit;
    assign w    = mealy_q ? m : w_q;

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        mealy_d = mealy_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        w_d     = m;
        if (load) begin
            pat_d   = pat_in;
            len_d   = LW'(clamp_len(int'(len_in), MAX_LEN));
            ovl_d   = overlap_en;
            mealy_d = mealy_mode;
            hist_d  = '0;
            fill_d  = '0;
            w_d     = 1'b0;
        end else if (valid) begin
            hist_d = win[MAX_LEN-2:0];
            fill_d = (m && !ovl_q) ? '0 : (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q   <= DEF_PAT;
            len_q   <= LW'(DEF_LEN);
            ovl_q   <= 1'b1;
            mealy_q <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            w_q     <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            mealy_q <= mealy_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            w_q     <= w_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (m),
        .clr  (clr),
        .q    (match_cnt),
        .sat  (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of the detector with a 4-bit match counter.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n, load, overlap_en, mealy_mode, clr, valid, j;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       w, cnt_sat;
    logic [3:0] match_cnt;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .pat_in    (pat_in),
        .len_in    (len_in),
        .overlap_en(overlap_en),
        .mealy_mode(mealy_mode),
        .clr       (clr),
        .valid     (valid),
        .j         (j),
        .w         (w),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one input bit on the falling edge, check w mid-cycle, then let the rising edge pass.
    task automatic cyc(input logic v, input logic b, input logic ew, input string tag);
        @(negedge clk);
        valid = v;
        j     = b;
        #1 chk(tag, 32'(w), 32'(ew));
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o,
                           input logic me, input logic v, input logic b);
        pat_in = p; len_in = l; overlap_en = o; mealy_mode = me; load = 1'b1;
        cyc(v, b, 1'b0, "load_w");
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; clr = 1'b0; valid = 1'b0; j = 1'b0;
        pat_in = '0; len_in = '0; overlap_en = 1'b0; mealy_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w", 32'(w), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        rst_n = 1'b1;
        // default 1001, overlapping, Mealy
        cyc(1, 1, 0, "t1_b1"); cyc(1, 0, 0, "t1_b2"); cyc(1, 0, 0, "t1_b3");
        cyc(1, 1, 1, "t1_b4"); cyc(1, 0, 0, "t1_b5"); cyc(1, 0, 0, "t1_b6");
        cyc(1, 1, 1, "t1_b7");
        chk("t1_cnt", 32'(match_cnt), 2);
        clr = 1'b1;
        cyc(0, 0, 0, "clr_w");
        clr = 1'b0;
        chk("clr_cnt", 32'(match_cnt), 0);
        // non-overlapping
        do_load(8'h09, 4'd4, 0, 1, 0, 0);
        cyc(1, 1, 0, "t2_b1"); cyc(1, 0, 0, "t2_b2"); cyc(1, 0, 0, "t2_b3");
        cyc(1, 1, 1, "t2_b4"); cyc(1, 0, 0, "t2_b5"); cyc(1, 0, 0, "t2_b6");
        cyc(1, 1, 0, "t2_b7");
        chk("t2_cnt", 32'(match_cnt), 1);
        // Moore: pulse one cycle after the final bit
        do_load(8'h09, 4'd4, 1, 0, 0, 0);
        cyc(1, 1, 0, "t3_b1"); cyc(1, 0, 0, "t3_b2"); cyc(1, 0, 0, "t3_b3");
        cyc(1, 1, 0, "t3_b4");
        chk("t3_cnt", 32'(match_cnt), 2);
        cyc(0, 0, 1, "t3_pulse"); cyc(0, 0, 0, "t3_after");
        // gaps with junk data on j
        do_load(8'h09, 4'd4, 1, 1, 0, 0);
        cyc(1, 1, 0, "t4_b1"); cyc(0, 1, 0, "t4_g1"); cyc(1, 0, 0, "t4_b2");
        cyc(0, 1, 0, "t4_g2"); cyc(1, 0, 0, "t4_b3"); cyc(0, 1, 0, "t4_g3");
        cyc(1, 1, 1, "t4_b4"); cyc(0, 1, 0, "t4_g4");
        chk("t4_cnt", 32'(match_cnt), 3);
        // len_in = 0 clamps to 1
        do_load(8'h01, 4'd0, 1, 1, 0, 0);
        cyc(1, 1, 1, "len0_b1"); cyc(1, 0, 0, "len0_b2"); cyc(1, 1, 1, "len0_b3");
        chk("len0_cnt", 32'(match_cnt), 5);
        // len_in = 15 clamps to 8, pattern 1010_0101
        do_load(8'hA5, 4'd15, 1, 1, 0, 0);
        cyc(1, 1, 0, "len15_b1"); cyc(1, 0, 0, "len15_b2"); cyc(1, 1, 0, "len15_b3");
        cyc(1, 0, 0, "len15_b4"); cyc(1, 0, 0, "len15_b5"); cyc(1, 1, 0, "len15_b6");
        cyc(1, 0, 0, "len15_b7"); cyc(1, 1, 1, "len15_b8");
        chk("len15_cnt", 32'(match_cnt), 6);
        // bit presented with load is dropped, so 0,0,1 alone cannot complete 1001
        do_load(8'h09, 4'd4, 1, 1, 1, 1);
        cyc(1, 0, 0, "ldv_b2"); cyc(1, 0, 0, "ldv_b3"); cyc(1, 1, 0, "ldv_b4");
        chk("ldv_cnt", 32'(match_cnt), 6);
        // reset mid-pattern
        do_load(8'h09, 4'd4, 1, 1, 0, 0);
        cyc(1, 1, 0, "rm_b1"); cyc(1, 0, 0, "rm_b2"); cyc(1, 0, 0, "rm_b3");
        rst_n = 1'b0;
        cyc(1, 1, 0, "rm_rst_w");
        chk("rm_rst_cnt", 32'(match_cnt), 0);
        rst_n = 1'b1;
        cyc(1, 1, 0, "rm_b4");
        chk("rm_cnt", 32'(match_cnt), 0);
        // saturation with single-bit pattern
        do_load(8'h01, 4'd1, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 1, "sat_w");
            if (i == 13) chk("sat_cnt14", 32'(match_cnt), 14);
        end
        chk("sat_cnt", 32'(match_cnt), 15);
        chk("sat_flag", 32'(cnt_sat), 1);
        mealy_mode = 1'b0;
        cyc(1, 1, 1, "nold_mode_w");
        clr = 1'b1;
        cyc(1, 1, 1, "clr_m_w");
        clr = 1'b0;
        chk("clr_m_cnt", 32'(match_cnt), 0);
        chk("clr_m_sat", 32'(cnt_sat), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
